wave_addr_gen: RTL and testbench

WAVE_ADDR_GEN -- requirements
Module: wave_addr_gen

---
 rtl/wave_pkg.sv | 14 +
 rtl/phase_acc.sv | 47 ++++
 rtl/wave_addr_gen.sv | 127 ++++++++++++
 tb/tb_wave_addr_gen.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// Shared defaults and state type for the wavetable address generator.
package wave_pkg;

  localparam int PHASE_W_DEF = 16;
  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/phase_acc.sv
// Phase accumulator with carry-out and a free-running 8-bit period counter.
module phase_acc #(
  parameter int PHASE_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               step,
  input  logic [PHASE_W-1:0] tw,
  output logic [PHASE_W-1:0] phase,
  output logic               carry,
  output logic [7:0]         periods
);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [7:0]         per_q, per_d;
  logic [PHASE_W:0]   sum;

  always_comb begin
    sum     = {1'b0, phase_q} + {1'b0, tw};
    phase_d = phase_q;
    per_d   = per_q;
    if (clear) begin
      phase_d = '0;
      per_d   = '0;
    end else if (step) begin
      phase_d = sum[PHASE_W-1:0];
      if (sum[PHASE_W])
        per_d = per_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      per_q   <= '0;
    end else begin
      phase_q <= phase_d;
      per_q   <= per_d;
    end
  end

  assign phase   = phase_q;
  assign carry   = sum[PHASE_W];
  assign periods = per_q;

endmodule

// File: rtl/wave_addr_gen.sv
// DDS-style wavetable playback: steps a ROM address by a tuning word and
// streams samples over a valid/ready output for a set number of periods.
module wave_addr_gen
  import wave_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               nReset,
  input  logic               start,
  input  logic               stop,
  input  logic [PHASE_W-1:0] tuning_word,
  input  logic [7:0]         n_periods,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  output logic [DATA_W-1:0]  sample_out,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               busy,
  output logic               done
);

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] tw_q, tw_d;
  logic [7:0]         np_q, np_d;
  logic [DATA_W-1:0]  sample_q, sample_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;

  logic               clr;
  logic               cap;
  logic               carry;
  logic               last;
  logic [PHASE_W-1:0] phase;
  logic [7:0]         periods;

  phase_acc #(
    .PHASE_W (PHASE_W)
  ) u_acc (
    .clk     (clk),
    .rst_n   (nReset),
    .clear   (clr),
    .step    (cap),
    .tw      (tw_q),
    .phase   (phase),
    .carry   (carry),
    .periods (periods)
  );

  assign cap = (state_q == ST_RUN) && !stop
             && (!valid_q || sample_ready);

  // The sample captured on the wrap that completes the last period ends playback.
  assign last = carry && (np_q != 8'd0)
              && ((periods + 8'd1) == np_q);

  always_comb begin
    state_d  = state_q;
    tw_d     = tw_q;
    np_d     = np_q;
    sample_d = sample_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    clr      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          tw_d    = tuning_word;
          np_d    = n_periods;
          clr     = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          if (valid_q && sample_ready)
            valid_d = 1'b0;
          if (cap) begin
            sample_d = rom_data;
            valid_d  = 1'b1;
            if (last)
              state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (stop || (valid_q && sample_ready)) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= ST_IDLE;
      tw_q     <= '0;
      np_q     <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tw_q     <= tw_d;
      np_q     <= np_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  assign rom_addr     = phase[PHASE_W-1 -: ADDR_W];
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;

endmodule

// File: tb/tb_wave_addr_gen.sv
// Randomized bench for wave_addr_gen against a queue-based playback model.
module tb_wave_addr_gen;

  logic        clk;
  logic        nReset;
  logic        start;
  logic        stop;
  logic [15:0] tuning_word;
  logic [7:0]  n_periods;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  sample_out;
  logic        sample_valid;
  logic        sample_ready;
  logic        busy;
  logic        done;

  logic [7:0]  rom [0:255];
  logic [7:0]  exp_q [$];
  int          checks;
  int          failures;

  wave_addr_gen #(
    .PHASE_W (16),
    .ADDR_W  (8),
    .DATA_W  (8)
  ) dut (
    .clk          (clk),
    .nReset       (nReset),
    .start        (start),
    .stop         (stop),
    .tuning_word  (tuning_word),
    .n_periods    (n_periods),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .done         (done)
  );

  assign rom_data = rom[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected sample stream: walk the phase as an integer and count overflows.
  task automatic build(input int tw, input int np, input int lim);
    int ph;
    int nxt;
    int per;
    ph  = 0;
    per = 0;
    exp_q.delete();
    forever begin
      exp_q.push_back(rom[ph / 256]);
      if (exp_q.size() >= lim) break;
      nxt = ph + tw;
      if (nxt >= 65536) begin
        nxt = nxt - 65536;
        per++;
        if (np != 0 && per == np) break;
      end
      ph = nxt;
    end
  endtask

  // mode: 0 ready always, 1 ready toggling, 2 ready random.
  // stop_after: 0 = run to natural end, else stop after that many transfers.
  task automatic play(input int tw, input int np, input int mode,
                      input int stop_after, input bit noisy);
    int  idx;
    int  cyc;
    bit  fin;
    bit  stopping;
    bit  pv;
    bit  pr;
    logic [7:0] ps;
    if (np == 0 || tw == 0) build(tw, np, stop_after + 2);
    else build(tw, np, 100000);
    tuning_word  = 16'(tw);
    n_periods    = 8'(np);
    start        = 1'b1;
    stop         = 1'b0;
    sample_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_valid", 32'(sample_valid), 32'd0);
    idx = 0;
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < 3000) begin
      stopping = (stop_after != 0) && (idx == stop_after);
      case (mode)
        0:       pr = 1'b1;
        1:       pr = (cyc % 2 == 0);
        default: pr = 1'($urandom_range(0, 1));
      endcase
      if (stopping) pr = 1'b0;
      sample_ready = pr;
      stop         = stopping;
      if (noisy) begin
        start       = 1'($urandom_range(0, 1));
        tuning_word = 16'($urandom);
        n_periods   = 8'($urandom);
      end
      pv = sample_valid;
      ps = sample_out;
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1)
        chk("first_valid", 32'(sample_valid), 32'd1);
      if (stopping) begin
        chk("stop_valid", 32'(sample_valid), 32'd0);
        chk("stop_done", 32'(done), 32'd1);
        chk("stop_busy", 32'(busy), 32'd0);
        fin = 1'b1;
      end else begin
        if (pv && pr) begin
          if (idx < exp_q.size())
            chk("sample", 32'(ps), 32'(exp_q[idx]));
          else
            chk("extra_sample", 32'(idx), 32'(exp_q.size()));
          idx++;
          if (stop_after == 0 && idx == exp_q.size())
            chk("done_at_last", 32'(done), 32'd1);
        end else if (pv) begin
          chk("stall_data", 32'(sample_out), 32'(ps));
          chk("stall_valid", 32'(sample_valid), 32'd1);
        end
        if (done) begin
          chk("done_count", 32'(idx), 32'(exp_q.size()));
          chk("done_busy", 32'(busy), 32'd0);
          chk("done_valid", 32'(sample_valid), 32'd0);
          fin = 1'b1;
        end
      end
    end
    if (!fin) chk("timeout", 32'd0, 32'd1);
    start        = 1'b0;
    stop         = 1'b0;
    sample_ready = 1'b0;
    @(posedge clk); #1;
    chk("done_pulse", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    start        = 1'b0;
    stop         = 1'b0;
    sample_ready = 1'b0;
    tuning_word  = '0;
    n_periods    = '0;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    nReset = 1'b0;
    #1;
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_sample", 32'(sample_out), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #2 nReset = 1'b1;
    @(posedge clk); #1;

    play(16'h0100, 1, 0, 0, 1'b0);
    play(16'h8000, 3, 0, 0, 1'b0);
    play(16'h0100, 1, 1, 0, 1'b0);
    play(16'h0100, 0, 0, 10, 1'b0);
    play(16'h0100, 1, 2, 0, 1'b0);

    start = 1'b1;
    stop  = 1'b1;
    tuning_word = 16'h4000;
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
    chk("start_stop_idle", 32'(busy), 32'd0);
    chk("start_stop_valid", 32'(sample_valid), 32'd0);

    play(16'h8000, 2, 2, 0, 1'b1);
    play(0, 1, 2, 20, 1'b0);
    play(16'h2000, 0, 1, 12, 1'b1);
    for (int k = 0; k < 8; k++)
      play(int'($urandom_range(16'h0400, 16'hFFFF)),
           int'($urandom_range(1, 3)), 2, 0, 1'b1);

    tuning_word  = 16'h0100;
    n_periods    = 8'd0;
    start        = 1'b1;
    sample_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #3 nReset = 1'b0;
    #1;
    chk("mid_rst_addr", 32'(rom_addr), 32'd0);
    chk("mid_rst_sample", 32'(sample_out), 32'd0);
    chk("mid_rst_valid", 32'(sample_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("rst_no_done", 32'(done), 32'd0);
    end
    nReset = 1'b1;
    sample_ready = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_done", 32'(done), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    play(16'h4000, 1, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
